ks_adder_pipe: RTL and testbench
================================

// Module: ks_adder_pipe
// PURPOSE
//  Parametrised, pipelined Kogge-Stone adder: A + B + CIN over WIDTH bits.
//  Successor to the fixed 16-bit combinational prefix layers; prefix tree
//  is generated per level (black cells where P needed, gray cells otherwise).
//  Pipeline registers are inserted every REG_EVERY levels.
//  Sits between operand sources and consumers; valid/ready on both sides.
// PARAMETERS
//  WIDTH      16  operand width; power of 2, 4..64
//  REG_EVERY  1   prefix levels per pipeline register; 1..log2(WIDTH)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operands valid
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry in
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  A+B+CIN, low WIDTH bits
//  cout       out  1      carry out
//  ovf        out  1      signed overflow (KS_OVF_EN only)
// BEHAVIOUR
//  - L = log2(WIDTH) prefix levels; level k span 2^k; CIN folded as G[-1].
//  - Stage 0 registers P=a^b, G=a&b, cin. Then one register per REG_EVERY
//    levels (last group partial). Sum/cout XOR stage registered at output.
//  - Latency LAT = 2 + ceil(L/REG_EVERY) cycles accept->out_valid.
//    WIDTH=16: REG_EVERY=1 -> 6; REG_EVERY=2 -> 4; REG_EVERY=4 -> 3.
//  - One valid bit per stage. Global advance enable
//    en = !out_valid | out_ready; in_ready = en (combinational).
//  - Accept on in_valid & in_ready; result leaves on out_valid & out_ready.
//  - Stall (out_valid & !out_ready): all stages hold; sum/cout/ovf stable.
//  - Bubbles not collapsed; throughput 1/cycle with out_ready held high.
//  - Simultaneous accept and output handshake same cycle: both occur.
//  - in_valid=0 with en=1 inserts bubble (stage valid=0, data don't-care).
//  - cout = carry out of bit WIDTH-1; sum wraps mod 2^WIDTH.
//  - Reset: all stage valids 0, out_valid 0, sum 0, cout 0, ovf 0;
//    in_ready=1 first cycle after reset. Reset mid-operation discards all
//    in-flight results; nothing emitted for them.
// CONFIGURATION
//  KS_OVF_EN defined: ovf = (a[W-1]==b[W-1]) & (sum[W-1]!=a[W-1]), carried
//    as operand sign bits down the pipe, aligned with sum; reset 0.
//  KS_OVF_EN undefined: ovf port absent, no sign-bit registers.
// TESTING
//  1 WIDTH=16,RE=1: a=FFFF b=0001 cin=0 -> sum=0000 cout=1 after 6 cycles.
//  2 a=1234 b=4321 cin=1, out_ready=0 10 cycles -> sum=5556 held stable,
//    in_ready=0 while out_valid; release -> exactly one transfer.
//  3 100 back-to-back random ops, out_ready=1 -> 100 results in order,
//    one per cycle, match reference model; repeat with random out_ready.
//  4 rst high 1 cycle with 3 ops in flight -> out_valid=0 next cycle,
//    no stale results emitted; next op result after LAT cycles.
//  5 KS_OVF_EN: a=7FFF b=0001 -> ovf=1; a=8000 b=FFFF -> ovf=1,cout=1;
//    a=0001 b=0001 -> ovf=0.
//  6 WIDTH=64,RE=4: a=all-ones b=0 cin=1 -> sum=0 cout=1 after 4 cycles.

Source files
------------

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready handshake; registers every REG_EVERY prefix levels.
// Optional signed-overflow output enabled by defining KS_OVF_EN.
module ks_adder_pipe #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned REG_EVERY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef KS_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned L    = $clog2(WIDTH);
    localparam int unsigned NSTG = (L + REG_EVERY - 1) / REG_EVERY;

    logic             en;
    logic [WIDTH-1:0] g_q  [NSTG+1];
    logic [WIDTH-1:0] g_d  [NSTG+1];
    logic [WIDTH-1:0] pg_q [NSTG];
    logic [WIDTH-1:0] pg_d [NSTG];
    logic [WIDTH-1:0] ps_q [NSTG+1];
    logic [WIDTH-1:0] ps_d [NSTG+1];
    logic [NSTG:0]    cin_q, cin_d;
    logic [NSTG:0]    vld_q, vld_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef KS_OVF_EN
    logic [NSTG:0]    sa_q, sa_d, sb_q, sb_d;
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        logic [WIDTH-1:0] g, p, gn, pn;
        int unsigned      lvl, span;
        g    = '0;
        p    = '0;
        gn   = '0;
        pn   = '0;
        lvl  = 0;
        span = 0;

        en       = !out_valid_q || out_ready;
        in_ready = en;

        vld_d[0] = in_valid;
        g_d[0]   = a & b;
        pg_d[0]  = a ^ b;
        ps_d[0]  = a ^ b;
        cin_d[0] = cin;
`ifdef KS_OVF_EN
        sa_d[0]  = a[WIDTH-1];
        sb_d[0]  = b[WIDTH-1];
`endif
        for (int unsigned s = 1; s <= NSTG; s++) begin
            vld_d[s] = vld_q[s-1];
            ps_d[s]  = ps_q[s-1];
            cin_d[s] = cin_q[s-1];
`ifdef KS_OVF_EN
            sa_d[s]  = sa_q[s-1];
            sb_d[s]  = sb_q[s-1];
`endif
            g = g_q[s-1];
            p = pg_q[s-1];
            // Carry-in folded into bit 0 so L levels reach every position.
            if (s == 1) g[0] = g[0] | (p[0] & cin_q[0]);
            for (int unsigned k = 0; k < REG_EVERY; k++) begin
                lvl = (s - 1) * REG_EVERY + k;
                if (lvl < L) begin
                    span = 32'd1 << lvl;
                    gn   = g;
                    pn   = p;
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (i >= span) begin
                            gn[i] = g[i] | (p[i] & g[i-span]);
                            if (i >= 2 * span) pn[i] = p[i] & p[i-span];
                        end
                    end
                    g = gn;
                    p = pn;
                end
            end
            g_d[s] = g;
            if (s < NSTG) pg_d[s] = p;
        end

        out_valid_d = vld_q[NSTG];
        sum_d       = ps_q[NSTG] ^ {g_q[NSTG][WIDTH-2:0], cin_q[NSTG]};
        cout_d      = g_q[NSTG][WIDTH-1];
`ifdef KS_OVF_EN
        ovf_d       = (sa_q[NSTG] == sb_q[NSTG]) && (sum_d[WIDTH-1] != sa_q[NSTG]);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
`ifdef KS_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else if (en) begin
            vld_q       <= vld_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
`ifdef KS_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            g_q   <= g_d;
            pg_q  <= pg_d;
            ps_q  <= ps_d;
            cin_q <= cin_d;
`ifdef KS_OVF_EN
            sa_q  <= sa_d;
            sb_q  <= sb_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef KS_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe: 16-bit/REG_EVERY=1 instance plus a 64-bit/REG_EVERY=4 instance.
module tb_ks_adder_pipe;

    localparam int unsigned LAT = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, cin, out_valid, out_ready, cout;
    logic [15:0] a, b, sum;
`ifdef KS_OVF_EN
    logic        ovf, ovf64;
`endif
    logic        iv64, ir64, ov64, cin64, cout64;
    logic [63:0] a64, b64, s64;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;
    exp_t sbq[$];

    ks_adder_pipe #(.WIDTH(16), .REG_EVERY(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
`ifdef KS_OVF_EN
        , .ovf(ovf)
`endif
    );

    ks_adder_pipe #(.WIDTH(64), .REG_EVERY(4)) dut64 (
        .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64),
        .a(a64), .b(b64), .cin(cin64), .out_valid(ov64), .out_ready(1'b1),
        .sum(s64), .cout(cout64)
`ifdef KS_OVF_EN
        , .ovf(ovf64)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per output handshake.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got sum %0h, required no output", sum);
                end else begin
                    e = sbq.pop_front();
                    chk("sum", {48'd0, sum}, {48'd0, e.s});
                    chk("cout", {63'd0, cout}, {63'd0, e.c});
`ifdef KS_OVF_EN
                    chk("ovf", {63'd0, ovf}, {63'd0, e.o});
`endif
                    pops++;
                end
            end
        end
    end

    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input logic [15:0] es, input logic ec, input logic eo, input bit rr);
        int unsigned n = 0;
        @(negedge clk);
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        if (rr) out_ready = 1'($urandom_range(0, 1));
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            if (rr) out_ready = 1'($urandom_range(0, 1));
            #1;
            n++;
        end
        if (in_ready) sbq.push_back({es, ec, eo});
        else chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_rand(input bit rr);
        logic [15:0] ra, rb;
        logic        rc;
        logic [16:0] r;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom_range(0, 1));
        r  = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
        send(ra, rb, rc, r[15:0], r[16], (ra[15] == rb[15]) && (r[15] != ra[15]), rr);
    endtask

    task automatic wait_out(output int n);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, p0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
        iv64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {48'd0, sum}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid64", {63'd0, ov64}, 64'd0);

        // Test 1: wrap with carry out, latency
        send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        wait_out(n);
        chk("lat_t1", 64'(n), 64'(LAT));

        // Test 2: stall holds result, blocks input, single transfer on release
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b0);
        wait_out(n);
        chk("lat_t2", 64'(n), 64'(LAT));
        repeat (10) begin
            #1;
            chk("stall_sum", {48'd0, sum}, 64'h5556);
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            @(negedge clk);
        end
        p0 = pops;
        out_ready = 1'b1;
        @(negedge clk);
        #3;
        chk("one_transfer_pops", 64'(pops - p0), 64'd1);
        chk("one_transfer_valid", {63'd0, out_valid}, 64'd0);

        // Test 3: back-to-back throughput, then random backpressure
        p0 = pops;
        for (int unsigned i = 0; i < 100; i++) send_rand(1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (LAT) @(negedge clk);
        #3;
        chk("b2b_count", 64'(pops - p0), 64'd100);
        p0 = pops;
        for (int unsigned i = 0; i < 100; i++) send_rand(1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("rand_rdy_count", 64'(pops - p0), 64'd100);

        // Test 4: reset discards in-flight operations
        send(16'h0101, 16'h0202, 1'b0, 16'h0303, 1'b0, 1'b0, 1'b0);
        send(16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0, 1'b0);
        send(16'hF000, 16'h1000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        p0 = pops;
        repeat (10) @(negedge clk);
        chk("no_stale", 64'(pops - p0), 64'd0);
        send(16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        wait_out(n);
        chk("lat_after_rst", 64'(n), 64'(LAT));

`ifdef KS_OVF_EN
        // Test 5: signed overflow
        send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        send(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        send(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
`endif

        // Test 6: 64-bit, REG_EVERY=4
        @(negedge clk);
        a64 = '1; b64 = '0; cin64 = 1'b1; iv64 = 1'b1;
        #1;
        chk("w64_in_ready", {63'd0, ir64}, 64'd1);
        @(negedge clk);
        iv64 = 1'b0;
        n = 1;
        while (!ov64 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("w64_lat", 64'(n), 64'd4);
        chk("w64_sum", s64, 64'd0);
        chk("w64_cout", {63'd0, cout64}, 64'd1);

        // Drain remaining expectations
        out_ready = 1'b1;
        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("drain_empty", 64'(sbq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
